// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the 640x480 @ 60 Hz VGA raster.
// Holds the timing numbers, derived totals, colour constants and a small
// window-compare helper used by the axis counters.
package vga_pkg;

  localparam int COORD_W = 11;

  // Horizontal timing, in pixel clocks
  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;  // 800

  // Vertical timing, in lines
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;  // 525

  // Level driven on hs/vs while the sync pulse is active
  localparam logic SYNC_ACTIVE = 1'b0;

  // 12-bit colours, {R[3:0],G[3:0],B[3:0]}
  localparam logic [11:0] COLOR_BLACK = 12'h000;
  localparam logic [11:0] COLOR_RED   = 12'hF00;
  localparam logic [11:0] COLOR_BLUE  = 12'h00F;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // True when lo <= v < hi
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
// Counts 0..TOTAL-1 while enabled and wraps to 0. Besides the registered
// count it exposes the next count and the active/sync levels that the next
// count implies, so the parent can register its flags in lock-step with
// the counter.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   VISIBLE    = H_VISIBLE,
  parameter int   FP         = H_FP,
  parameter int   SYNC       = H_SYNC,
  parameter int   BP         = H_BP,
  parameter logic SYNC_LEVEL = SYNC_ACTIVE
) (
  input  logic               clk_25MHz,
  input  logic               reset,
  input  logic               enable,
  output logic [COORD_W-1:0] count,
  output logic [COORD_W-1:0] count_next,
  output logic               wrap,
  output logic               active_next,
  output logic               sync_next
);

  localparam int TOTAL = VISIBLE + FP + SYNC + BP;
  localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);

  logic [COORD_W-1:0] count_reg;

  // Next count, wrap strobe and the window flags derived from the next count
  always_comb begin
    wrap       = enable && (count_reg == LAST);
    count_next = count_reg;
    if (wrap) begin
      count_next = '0;
    end else if (enable) begin
      count_next = count_reg + COORD_W'(1);
    end
    active_next = in_window(count_next, 0, VISIBLE);
    sync_next   = in_window(count_next, VISIBLE + FP, VISIBLE + FP + SYNC)
                  ? SYNC_LEVEL : ~SYNC_LEVEL;
  end

  // Counter register, cleared immediately by reset
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480 @ 60 Hz VGA timing generator on the 25 MHz clock.
// Produces hcount/vcount/blank/frame_end for the drawing blocks, hs/vs for
// the connector, and gates the drawing block's colour to black in blanking.
// Build option: define VGA_PIPE_ALIGN_EN to register colorIn and delay hs,
// vs and the RGB blanking by one clock, matching a drawing block whose
// colour output is registered. Raster outputs are unaffected by it.
module vga_timing_gen
  import vga_pkg::*;
(
  input  logic               clk_25MHz,
  input  logic               reset,
  input  logic [11:0]        colorIn,
  output logic [COORD_W-1:0] hcount,
  output logic [COORD_W-1:0] vcount,
  output logic               blank,
  output logic               frame_end,
  output logic               hs,
  output logic               vs,
  output logic [3:0]         vgaRed,
  output logic [3:0]         vgaGreen,
  output logic [3:0]         vgaBlue
);

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  logic [COORD_W-1:0] h_count_next;
  logic [COORD_W-1:0] v_count_next;
  logic               h_wrap;
  logic               v_wrap_unused;
  logic               h_active_next;
  logic               v_active_next;
  logic               h_sync_next;
  logic               v_sync_next;

  logic blank_reg, blank_next;
  logic frame_end_reg, frame_end_next;
  logic hs_reg, vs_reg;

  vga_axis_counter #(
    .VISIBLE    (H_VISIBLE),
    .FP         (H_FP),
    .SYNC       (H_SYNC),
    .BP         (H_BP),
    .SYNC_LEVEL (SYNC_ACTIVE)
  ) u_h_axis (
    .clk_25MHz   (clk_25MHz),
    .reset       (reset),
    .enable      (1'b1),
    .count       (hcount),
    .count_next  (h_count_next),
    .wrap        (h_wrap),
    .active_next (h_active_next),
    .sync_next   (h_sync_next)
  );

  // The line counter steps only when the pixel counter wraps
  vga_axis_counter #(
    .VISIBLE    (V_VISIBLE),
    .FP         (V_FP),
    .SYNC       (V_SYNC),
    .BP         (V_BP),
    .SYNC_LEVEL (SYNC_ACTIVE)
  ) u_v_axis (
    .clk_25MHz   (clk_25MHz),
    .reset       (reset),
    .enable      (h_wrap),
    .count       (vcount),
    .count_next  (v_count_next),
    .wrap        (v_wrap_unused),
    .active_next (v_active_next),
    .sync_next   (v_sync_next)
  );

  // Raster flags for the position the counters are about to enter
  always_comb begin
    blank_next     = ~(h_active_next & v_active_next);
    frame_end_next = (h_count_next == H_LAST) && (v_count_next == V_LAST);
  end

  // Flag registers; reset state matches position (0,0), which is visible
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      blank_reg     <= 1'b0;
      frame_end_reg <= 1'b0;
      hs_reg        <= ~SYNC_ACTIVE;
      vs_reg        <= ~SYNC_ACTIVE;
    end else begin
      blank_reg     <= blank_next;
      frame_end_reg <= frame_end_next;
      hs_reg        <= h_sync_next;
      vs_reg        <= v_sync_next;
    end
  end

  assign blank     = blank_reg;
  assign frame_end = frame_end_reg;

  logic [11:0] color_src;
  logic        blank_gate;

`ifdef VGA_PIPE_ALIGN_EN
  logic [11:0] color_reg;
  logic        blank_d_reg;
  logic        hs_d_reg;
  logic        vs_d_reg;

  // One-clock alignment stage for colour, blanking and syncs
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      color_reg   <= COLOR_BLACK;
      blank_d_reg <= 1'b1;
      hs_d_reg    <= ~SYNC_ACTIVE;
      vs_d_reg    <= ~SYNC_ACTIVE;
    end else begin
      color_reg   <= colorIn;
      blank_d_reg <= blank_reg;
      hs_d_reg    <= hs_reg;
      vs_d_reg    <= vs_reg;
    end
  end

  assign color_src  = color_reg;
  assign blank_gate = blank_d_reg;
  assign hs         = hs_d_reg;
  assign vs         = vs_d_reg;
`else
  assign color_src  = colorIn;
  assign blank_gate = blank_reg;
  assign hs         = hs_reg;
  assign vs         = vs_reg;
`endif

  // Per-channel blanking: channel 0 is red (bits 11:8), 2 is blue (3:0)
  logic [3:0] chan [3];
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign chan[gi] = blank_gate ? 4'h0 : color_src[11 - 4*gi -: 4];
  end

  rgb_t pin_rgb;
  assign pin_rgb  = {chan[0], chan[1], chan[2]};
  assign vgaRed   = pin_rgb.r;
  assign vgaGreen = pin_rgb.g;
  assign vgaBlue  = pin_rgb.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// A reference raster position is kept by counting clocks since reset
// release; expected outputs are queued when colour is driven and popped
// against the DUT on the falling edge.
module tb_vga_timing_gen;

  logic        clk_25MHz = 1'b0;
  logic        reset;
  logic [11:0] colorIn;
  logic [10:0] hcount, vcount;
  logic        blank, frame_end, hs, vs;
  logic [3:0]  vgaRed, vgaGreen, vgaBlue;

  vga_timing_gen dut (
    .clk_25MHz (clk_25MHz),
    .reset     (reset),
    .colorIn   (colorIn),
    .hcount    (hcount),
    .vcount    (vcount),
    .blank     (blank),
    .frame_end (frame_end),
    .hs        (hs),
    .vs        (vs),
    .vgaRed    (vgaRed),
    .vgaGreen  (vgaGreen),
    .vgaBlue   (vgaBlue)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        bl;
    logic        fe;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  exp_t        sb_q[$];
  int          tests  = 0;
  int          failed = 0;
  int          n;          // clocks since reset release = raster position
  logic        prev_hs, prev_vs;
  logic [11:0] prev_rgb;
  int          hs_low, vs_low, fe_seen, fe_pos;

  task automatic summary_and_finish();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h at position %0d", tag, obs, exp, n);
    end
    if (failed >= 20) summary_and_finish();
  endtask

  // Reference raster for 800x525, sync 656..751 / 490..491, active low
  function automatic exp_t model(input int pos, input logic [11:0] c);
    exp_t e;
    int hx, vy;
    hx    = pos % 800;
    vy    = (pos / 800) % 525;
    e.hc  = 11'(hx);
    e.vc  = 11'(vy);
    e.bl  = (hx >= 640) || (vy >= 480);
    e.fe  = (hx == 799) && (vy == 524);
    e.hs  = !((hx >= 656) && (hx < 752));
    e.vs  = !((vy >= 490) && (vy < 492));
    e.rgb = e.bl ? 12'h000 : c;
    return e;
  endfunction

  task automatic compare_pop();
    exp_t e;
    e = sb_q.pop_front();
    chk("hcount",    32'(hcount),    32'(e.hc));
    chk("vcount",    32'(vcount),    32'(e.vc));
    chk("blank",     32'(blank),     32'(e.bl));
    chk("frame_end", 32'(frame_end), 32'(e.fe));
    chk("hs",        32'(hs),        32'(e.hs));
    chk("vs",        32'(vs),        32'(e.vs));
    chk("rgb",       32'({vgaRed, vgaGreen, vgaBlue}), 32'(e.rgb));
  endtask

  task automatic clear_pipe_model();
    prev_hs  = 1'b1;
    prev_vs  = 1'b1;
    prev_rgb = 12'h000;
  endtask

  // Called at posedge+1 of state n: drive colour, queue expectation,
  // compare on the falling edge, then advance to the next state.
  task automatic run_state(input logic [11:0] c);
    exp_t        e;
    logic        h0, v0;
    logic [11:0] r0;
    colorIn = c;
    e = model(n, c);
`ifdef VGA_PIPE_ALIGN_EN
    h0 = e.hs; v0 = e.vs; r0 = e.rgb;
    e.hs = prev_hs; e.vs = prev_vs; e.rgb = prev_rgb;
    prev_hs = h0; prev_vs = v0; prev_rgb = r0;
`else
    h0 = 1'b0; v0 = 1'b0; r0 = 12'h000;
`endif
    sb_q.push_back(e);
    @(negedge clk_25MHz);
    compare_pop();
    if (n < 800 && hs === 1'b0) hs_low++;
    if (n < 420000 && vs === 1'b0) vs_low++;
    if (n < 420000 && frame_end === 1'b1) begin
      fe_seen++;
      fe_pos = n;
    end
    @(posedge clk_25MHz);
    #1;
    n++;
  endtask

  // Expected outputs while reset is held: position (0,0), syncs idle
  task automatic reset_check(input logic [11:0] c);
    exp_t e;
    e.hc = 11'd0; e.vc = 11'd0; e.bl = 1'b0; e.fe = 1'b0;
    e.hs = 1'b1;  e.vs = 1'b1;
`ifdef VGA_PIPE_ALIGN_EN
    e.rgb = 12'h000;
`else
    e.rgb = c;
`endif
    sb_q.push_back(e);
    compare_pop();
  endtask

  initial begin
    reset   = 1'b1;
    colorIn = 12'hF00;
    n       = 0;
    hs_low  = 0; vs_low = 0; fe_seen = 0; fe_pos = -1;
    clear_pipe_model();

    // Reset state
    repeat (3) @(posedge clk_25MHz);
    @(negedge clk_25MHz);
    reset_check(12'hF00);

    // Release, run to (300,200) with random colour
    @(posedge clk_25MHz);
    #1;
    reset = 1'b0;
    n = 0;
    clear_pipe_model();
    while (n < 200 * 800 + 300) run_state(12'($urandom_range(0, 4095)));

    // Asynchronous reset mid-frame, away from the clock edge
    colorIn = 12'hF00;
    @(negedge clk_25MHz);
    chk("pre_reset_hcount", 32'(hcount), 32'd300);
    chk("pre_reset_vcount", 32'(vcount), 32'd200);
    #5;
    reset = 1'b1;
    #1;
    reset_check(12'hF00);
    @(posedge clk_25MHz);
    @(negedge clk_25MHz);
    reset_check(12'hF00);
    @(posedge clk_25MHz);
    #1;
    reset = 1'b0;
    n = 0;
    clear_pipe_model();
    hs_low = 0; vs_low = 0; fe_seen = 0; fe_pos = -1;

    // One full frame with constant red, plus the first state of the next
    while (n <= 420000) run_state(12'hF00);

    chk("hs_low_clocks_line0", 32'(hs_low),  32'd96);
    chk("vs_low_clocks_frame", 32'(vs_low),  32'd1600);
    chk("frame_end_pulses",    32'(fe_seen), 32'd1);
    chk("frame_end_position",  32'(fe_pos),  32'd419999);

    summary_and_finish();
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- 640x480 @ 60 Hz VGA timing generator, driven from the 25 MHz pixel clock.
- Produces the hcount/vcount/blank raster interface consumed by the pixel-drawing blocks, plus hs/vs sync outputs.
- Gates the drawing block's 12-bit colour onto the VGA pins, forcing black during blanking.
- Sits between the clock divider and the board VGA connector; the drawing blocks hang off its raster outputs.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE, 1'b0, level of hs/vs during the sync pulse

Ports:
clk_25MHz  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
colorIn  in  12  {R[3:0],G[3:0],B[3:0]} from the drawing block
hcount  out  11  current pixel column, 0..H_TOTAL-1
vcount  out  11  current line, 0..V_TOTAL-1
blank  out  1  high outside the visible 640x480 region
frame_end  out  1  one-cycle pulse on the last pixel of the frame
hs  out  1  horizontal sync to connector
vs  out  1  vertical sync to connector
vgaRed  out  4  red to connector
vgaGreen  out  4  green to connector
vgaBlue  out  4  blue to connector

Behaviour:
- Clock and reset: one clock, clk_25MHz; reset is asynchronous and active-high.
- Derived totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Registers: hcount, vcount, blank, hs, vs and frame_end are all registers. Each is loaded from next-state logic computed from the next counter values, so all six are mutually consistent in every cycle.
- Counter sequence:
  - hcount increments by 1 each clock.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - When vcount is at V_TOTAL-1 and hcount wraps, vcount wraps to 0.
  - Counter arithmetic is 11-bit unsigned; values never exceed TOTAL-1.
- blank = 1 iff hcount >= H_VISIBLE or vcount >= V_VISIBLE.
- hs = SYNC_ACTIVE iff H_VISIBLE+H_FP <= hcount < H_VISIBLE+H_FP+H_SYNC (656..751); otherwise ~SYNC_ACTIVE.
- vs = SYNC_ACTIVE iff V_VISIBLE+V_FP <= vcount < V_VISIBLE+V_FP+V_SYNC (490..491); otherwise ~SYNC_ACTIVE.
  - vs changes coincident with hcount wrapping to 0.
- frame_end = 1 exactly in the cycle where (hcount,vcount) = (H_TOTAL-1, V_TOTAL-1).
- Colour: vgaRed/Green/Blue = blank ? 0 : colorIn fields. This path is combinational from colorIn and registered blank.
- Reset values: hcount 0, vcount 0, blank 0, hs ~SYNC_ACTIVE, vs ~SYNC_ACTIVE, frame_end 0. RGB follows the colour rule.
- Reset mid-frame: counters return to (0,0) immediately. The first frame after release is full-length, i.e. 420000 clocks to the first frame_end.
- Frame period: exactly H_TOTAL*V_TOTAL = 420000 clocks (about 59.5 Hz).

Optional Feature:
- Macro: VGA_PIPE_ALIGN_EN
- Defined:
  - colorIn is captured in a register stage; the blanked RGB is produced from that registered colour.
  - hs, vs and the blank used for RGB gating are each delayed one clock, so pins stay aligned with a drawing block that registers its colour output.
  - hcount/vcount/blank/frame_end ports are unchanged (stage 0).
  - Reset values of the delay registers: hs/vs ~SYNC_ACTIVE, RGB 0.
- Undefined: the zero-latency behaviour above.

Decomposition:
- Shared package vga_pkg:
  - timing constants (H_VISIBLE..V_BP, H_TOTAL, V_TOTAL)
  - colour constants (black, red, blue, 12-bit)
  - COORD_W = 11
- Natural sub-module: vga_axis_counter, instantiated twice.
  - Parameterised by VISIBLE, FP, SYNC, BP.
  - Inputs: enable and clock/reset.
  - Outputs: count, wrap, active, sync.
  - The horizontal instance is always enabled; its wrap enables the vertical instance.

Test Plan:
- Reset, then release and run 420000 clocks -> frame_end pulses once at cycle 419999 (counting the first clock after release as 0), with hcount=799 and vcount=524; the next cycle gives hcount=0, vcount=0.
- Observe one line -> blank 0 for hcount 0..639 and 1 for 640..799. hs low exactly for hcount 656..751, i.e. 96 clocks, giving 800 clocks per line.
- Observe one frame -> vs low for vcount 490..491 (1600 clocks); blank 1 for the whole of lines 480..524.
- Drive colorIn=12'hF00 constantly -> RGB = F,0,0 when blank=0 and 0,0,0 when blank=1, including hcount=640 and vcount=480 edges.
- Assert reset at (hcount=300, vcount=200) -> outputs at reset values immediately; after release, counting restarts from (0,0) with a full 420000-clock frame.
- With VGA_PIPE_ALIGN_EN: hs falling edge occurs one clock after hcount=656; RGB reflects the colorIn value from the previous cycle.
